instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
// - Inverse of the control unit's instruction decode: takes symbolic instruction fields (op, regs, imm)
//   and packs them into 32-bit RV32I words.
// - Streams the words into instruction memory through a sequential write port.
// - Used as the on-chip program loader ahead of the CPU, and by benches to build programs for the core.
// PARAMETERS
// - DATA_WIDTH  32  width of mem_wdata; must be 32.
// - ADDR_WIDTH  8   byte-address width of mem_addr; capacity = 2^(ADDR_WIDTH-2) words.
// - BASE_ADDR   0   byte address of the first write; word aligned (BASE_ADDR[1:0]==0).
// PORTS
// - clk        in   1             clock, rising edge.
// - rst        in   1             synchronous reset, active high.
// - clear      in   1             restarts the write pointer; clears count and err.
// - in_valid   in   1             instruction fields valid.
// - in_ready   out  1             loader can accept; transfer = in_valid & in_ready.
// - op         in   2             0=ADDI, 1=BNE, 2=LW, 3=illegal.
// - rd         in   5             destination register (ADDI/LW).
// - rs1        in   5             source register 1.
// - rs2        in   5             source register 2 (BNE).
// - imm        in   13            signed immediate; BNE byte offset uses imm[12:1].
// - pad_req    in   1             pad the rest of memory with NOPs (see CONFIGURATION).
// - mem_we     out  1             instruction-memory write enable.
// - mem_addr   out  ADDR_WIDTH    byte address of the current write.
// - mem_wdata  out  DATA_WIDTH    encoded instruction.
// - count      out  ADDR_WIDTH-1  number of words written since reset/clear.
// - full       out  1             last word slot written.
// - err        out  1             sticky flag: illegal op, or immediate out of range.
// BEHAVIOUR
// - Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0.
// - FSM state after reset: IDLE.
// - in_ready = (state==IDLE) & ~full & ~clear. It is combinational and is 0 while rst is high.
// - FSM states:
//   - IDLE: on transfer with a legal instruction -> WRITE; mem_wdata <= encoded word.
//   - WRITE: mem_we=1 for exactly 1 cycle. Then mem_addr += 4 and count += 1.
//     If mem_addr was the top word (all ones & ~3), set full=1 instead of incrementing mem_addr. -> IDLE.
//   - PAD: only with the macro enabled; see CONFIGURATION.
// - Latency and throughput: fields accepted at edge N appear with mem_we=1 in cycle N+1.
//   Throughput is 1 instruction per 2 cycles.
// - Encodings:
//   - ADDI: {imm[11:0], rs1, 3'b000, rd, 7'b0010011}
//   - LW:   {imm[11:0], rs1, 3'b010, rd, 7'b0000011}
//   - BNE:  {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'b1100011}
// - Error cases. The transfer is consumed, err<=1, no write, state stays IDLE:
//   - op==3.
//   - ADDI/LW with imm[12]!=imm[11] (does not fit 12-bit signed).
//   - BNE with imm[0]==1.
// - No wrap: when full=1, in_ready=0 and no write occurs until clear or rst.
// - clear: synchronous, lower priority than rst. Sets mem_addr=BASE_ADDR, count=0, full=0, err=0, state IDLE.
//   - A clear in WRITE or PAD aborts the FSM: the word driven in that cycle is still written, then the pointer is reset.
// - rst in WRITE: the word presented in that cycle is still written at the edge; everything is then reset.
// - in_valid while in_ready=0 is ignored. The source must hold its fields until the transfer.
// CONFIGURATION
// - Macro ENCODER_NOP_PAD_EN.
// - Defined:
//   - pad_req=1 in IDLE with ~full -> PAD.
//   - PAD writes 32'h00000013 (addi x0,x0,0) every cycle (mem_we=1) from the current mem_addr up to the top word.
//   - count increments per pad write; full=1 after the top word; then -> IDLE.
//   - in_ready=0 during PAD.
//   - pad_req together with in_valid in IDLE: pad_req wins, and the instruction is not accepted.
// - Not defined: pad_req is ignored, PAD does not exist, and the block is otherwise identical.
// TESTING
// - ADDI rd=1 rs1=0 imm=5 after reset -> next cycle mem_we=1, mem_addr=0x00, mem_wdata=0x00500093, then count=1.
// - LW rd=2 rs1=1 imm=4 as the 2nd instruction -> mem_addr=0x04, mem_wdata=0x0040A103.
// - BNE rs1=1 rs2=0 imm=-8 (13'h1FF8) -> mem_wdata=0xFE009CE3. Same BNE with imm=-7 -> err=1, no mem_we.
// - op=3 -> err=1, count unchanged, no write. Then clear=1 -> err=0, mem_addr=BASE_ADDR, count=0.
// - ADDR_WIDTH=4: 4 legal writes -> full=1, in_ready=0. A 5th in_valid held 10 cycles -> no mem_we.
// - ENCODER_NOP_PAD_EN, ADDR_WIDTH=4: 1 ADDI, then pad_req -> 0x00000013 written at 0x4, 0x8, 0xC on consecutive cycles; full=1, count=4.

Source files
------------

// File: rtl/instr_encoder_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_encoder_loader_if                                      |
// | Description : Bundles the loader's instruction-field input handshake, its  |
// |               sequential instruction-memory write port and its status      |
// |               outputs.                                                     |
// |               master : the program source (drives fields, clear, pad_req)  |
// |               slave  : the loader (drives in_ready, mem_*, count/full/err) |
// | Signals     : clear, in_valid, in_ready, op[1:0], rd/rs1/rs2[4:0],         |
// |               imm[12:0], pad_req, mem_we, mem_addr[ADDR_WIDTH-1:0],        |
// |               mem_wdata[DATA_WIDTH-1:0], count[ADDR_WIDTH-2:0], full, err  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface instr_encoder_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  clear;
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            op;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [12:0]           imm;
  logic                  pad_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH-2:0] count;
  logic                  full;
  logic                  err;

  modport master (
    output clear, in_valid, op, rd, rs1, rs2, imm, pad_req,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );

  modport slave (
    input  clear, in_valid, op, rd, rs1, rs2, imm, pad_req,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_encoder_loader                                         |
// | Description : Packs symbolic instruction fields (ADDI / BNE / LW) into     |
// |               32-bit RV32I words and streams them into instruction memory  |
// |               through a sequential write port, one word per two cycles.    |
// |               Illegal ops and out-of-range immediates set a sticky err and |
// |               are dropped. The pointer never wraps: once the top word is   |
// |               written, full holds off further input until clear or rst.    |
// | Ports       : clk  - clock, rising edge                                    |
// |               rst  - synchronous reset, active high                        |
// |               bus  - instr_encoder_loader_if.slave (fields in, memory      |
// |                      write port and count/full/err status out)             |
// | Parameters  : DATA_WIDTH (must be 32), ADDR_WIDTH (byte address bits),     |
// |               BASE_ADDR (word-aligned first write address)                 |
// | Options     : ENCODER_NOP_PAD_EN - adds a PAD state that fills the rest of |
// |               memory with NOPs on pad_req.                                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module instr_encoder_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input wire                    clk,
  input wire                    rst,
  instr_encoder_loader_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0]  c_op_addi       = 2'd0;
  localparam logic [1:0]  c_op_bne        = 2'd1;
  localparam logic [1:0]  c_op_lw         = 2'd2;

  localparam logic [6:0]  c_opc_op_imm    = 7'b0010011;
  localparam logic [6:0]  c_opc_load      = 7'b0000011;
  localparam logic [6:0]  c_opc_branch    = 7'b1100011;

  localparam logic [2:0]  c_f3_addi       = 3'b000;
  localparam logic [2:0]  c_f3_bne        = 3'b001;
  localparam logic [2:0]  c_f3_lw         = 3'b010;

  // addi x0, x0, 0
  localparam logic [31:0] c_nop           = 32'h0000_0013;

  localparam logic [ADDR_WIDTH-1:0] c_base_addr = ADDR_WIDTH'(BASE_ADDR);
  // Highest word-aligned byte address: all ones with the two LSBs cleared.
  localparam logic [ADDR_WIDTH-1:0] c_top_addr  = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [ADDR_WIDTH-1:0] c_addr_step = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-2:0] c_count_one = (ADDR_WIDTH-1)'(1);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
`ifdef ENCODER_NOP_PAD_EN
    S_PAD   = 2'd2,
`endif
    S_WRITE = 2'd1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [ADDR_WIDTH-2:0] r_count;
  logic                  r_full;
  logic                  r_err;

  logic [31:0]           w_enc;
  logic                  w_legal;
  logic                  w_in_ready;
  logic                  w_transfer;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_pad_go;
  logic                  w_pad_start;
  logic                  w_mem_we;
  logic                  w_at_top;

  // ---------------------------------------------------------------------------
  // Optional NOP padding request
  // ---------------------------------------------------------------------------
`ifdef ENCODER_NOP_PAD_EN
  // A pad request in IDLE takes precedence over a simultaneous instruction.
  assign w_pad_go = bus.pad_req & ~r_full;
`else
  // Without the padding feature pad_req has no effect at all.
  logic w_unused_pad_req;
  assign w_unused_pad_req = bus.pad_req;
  assign w_pad_go         = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // rst is folded in so the source never sees a ready while reset is applied.
  assign w_in_ready = (r_state == S_IDLE) & ~r_full & ~bus.clear & ~rst & ~w_pad_go;
  assign w_transfer = bus.in_valid & w_in_ready;
  assign w_accept   = w_transfer & w_legal;
  // Rejected transfers are still consumed; they only raise err.
  assign w_reject   = w_transfer & ~w_legal;

  assign w_pad_start = (r_state == S_IDLE) & w_pad_go & ~bus.clear & ~rst;
  assign w_at_top    = (r_mem_addr == c_top_addr);

  // ---------------------------------------------------------------------------
  // Instruction encoder and legality check
  // ---------------------------------------------------------------------------
  always_comb begin
    w_enc   = 32'd0;
    w_legal = 1'b0;
    case (bus.op)
      c_op_addi: begin
        w_enc   = {bus.imm[11:0], bus.rs1, c_f3_addi, bus.rd, c_opc_op_imm};
        // 12-bit signed range: bit 12 must be a copy of the sign bit 11.
        w_legal = (bus.imm[12] == bus.imm[11]);
      end
      c_op_lw: begin
        w_enc   = {bus.imm[11:0], bus.rs1, c_f3_lw, bus.rd, c_opc_load};
        w_legal = (bus.imm[12] == bus.imm[11]);
      end
      c_op_bne: begin
        // B-type scatters the 13-bit halfword offset; imm[0] is implicit zero.
        w_enc   = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, c_f3_bne,
                   bus.imm[4:1], bus.imm[11], c_opc_branch};
        w_legal = ~bus.imm[0];
      end
      default: begin
        w_enc   = 32'd0;
        w_legal = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and write strobe
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_mem_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.clear) begin
          w_state_next = S_IDLE;
`ifdef ENCODER_NOP_PAD_EN
        end else if (w_pad_start) begin
          w_state_next = S_PAD;
`endif
        end else if (w_accept) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        // Single-cycle write; a clear here still lets this word land.
        w_mem_we     = 1'b1;
        w_state_next = S_IDLE;
      end
`ifdef ENCODER_NOP_PAD_EN
      S_PAD: begin
        w_mem_we = 1'b1;
        if (bus.clear || w_at_top) begin
          w_state_next = S_IDLE;
        end
      end
`endif
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: write pointer, data, count, status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr  <= c_base_addr;
      r_mem_wdata <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_err       <= 1'b0;
    end else if (bus.clear) begin
      // mem_wdata is left alone: the word written this cycle must stay stable.
      r_mem_addr  <= c_base_addr;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem_wdata <= DATA_WIDTH'(w_enc);
      end
      if (w_pad_start) begin
        r_mem_wdata <= DATA_WIDTH'(c_nop);
      end
      if (w_reject) begin
        r_err <= 1'b1;
      end
      if (w_mem_we) begin
        r_count <= r_count + c_count_one;
        // The pointer parks on the top word rather than wrapping.
        if (w_at_top) begin
          r_full <= 1'b1;
        end else begin
          r_mem_addr <= r_mem_addr + c_addr_step;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.count     = r_count;
  assign bus.full      = r_full;
  assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_encoder_loader                                      |
// | Description : Self-checking bench for instr_encoder_loader with a 4-word   |
// |               memory (ADDR_WIDTH=4). Table of hand-encoded instructions    |
// |               plus directed sequences for full, clear and reset corners.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_instr_encoder_loader;

  localparam int c_aw = 4;
  localparam int c_dw = 32;

  logic clk;
  logic rst;

  instr_encoder_loader_if #(.DATA_WIDTH(c_dw), .ADDR_WIDTH(c_aw)) bus ();

  instr_encoder_loader #(
    .DATA_WIDTH (c_dw),
    .ADDR_WIDTH (c_aw),
    .BASE_ADDR  (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic        legal;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs [12];

  int n_vec;
  int n_fail;

  // Reference model of the write pointer and status.
  int   exp_count;
  int   exp_addr;
  logic exp_full;
  logic exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag);
    check({tag, " count"}, 32'(bus.count), 32'(exp_count));
    check({tag, " addr"},  32'(bus.mem_addr), 32'(exp_addr));
    check({tag, " full"},  32'(bus.full), 32'(exp_full));
    check({tag, " err"},   32'(bus.err), 32'(exp_err));
  endtask

  task automatic model_write();
    exp_count++;
    if (exp_addr == 12) exp_full = 1'b1;
    else                exp_addr += 4;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    #1;
    check("clear in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.clear = 1'b0;
    exp_count = 0;
    exp_addr  = 0;
    exp_full  = 1'b0;
    exp_err   = 1'b0;
    check_status("after clear");
  endtask

  task automatic apply(input vec_t v);
    if (exp_count == 4) begin
      check("full before clear", 32'(bus.full), 32'd1);
      check("full in_ready", 32'(bus.in_ready), 32'd0);
      do_clear();
    end
    bus.op  = v.op;
    bus.rd  = v.rd;
    bus.rs1 = v.rs1;
    bus.rs2 = v.rs2;
    bus.imm = v.imm;
    bus.in_valid = 1'b1;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("mem_we", 32'(bus.mem_we), 32'(v.legal));
    if (v.legal) begin
      check("mem_wdata", bus.mem_wdata, v.wdata);
      check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
      model_write();
    end else begin
      exp_err = 1'b1;
    end
    tick();
    check("idle mem_we", 32'(bus.mem_we), 32'd0);
    check_status("post");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec  = 0;
    n_fail = 0;
    //          op    rd     rs1    rs2    imm       legal  wdata
    vecs[0]  = '{2'd0, 5'd1,  5'd0,  5'd0,  13'h0005, 1'b1, 32'h0050_0093};
    vecs[1]  = '{2'd2, 5'd2,  5'd1,  5'd0,  13'h0004, 1'b1, 32'h0040_A103};
    vecs[2]  = '{2'd1, 5'd0,  5'd1,  5'd0,  13'h1FF8, 1'b1, 32'hFE00_9CE3};
    vecs[3]  = '{2'd1, 5'd0,  5'd1,  5'd0,  13'h1FF9, 1'b0, 32'h0};
    vecs[4]  = '{2'd3, 5'd1,  5'd2,  5'd3,  13'h0001, 1'b0, 32'h0};
    vecs[5]  = '{2'd0, 5'd31, 5'd31, 5'd0,  13'h1800, 1'b1, 32'h800F_8F93};
    vecs[6]  = '{2'd0, 5'd1,  5'd1,  5'd0,  13'h0800, 1'b0, 32'h0};
    vecs[7]  = '{2'd2, 5'd1,  5'd1,  5'd0,  13'h17FF, 1'b0, 32'h0};
    vecs[8]  = '{2'd2, 5'd5,  5'd10, 5'd0,  13'h07FF, 1'b1, 32'h7FF5_2283};
    vecs[9]  = '{2'd1, 5'd0,  5'd2,  5'd3,  13'h0FFE, 1'b1, 32'h7E31_1FE3};
    vecs[10] = '{2'd1, 5'd0,  5'd0,  5'd0,  13'h0002, 1'b1, 32'h0000_1163};
    vecs[11] = '{2'd3, 5'd0,  5'd0,  5'd0,  13'h0000, 1'b0, 32'h0};

    rst          = 1'b1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b1;
    bus.op       = 2'd0;
    bus.rd       = 5'd1;
    bus.rs1      = 5'd0;
    bus.rs2      = 5'd0;
    bus.imm      = 13'd5;
    bus.pad_req  = 1'b0;
    tick();
    tick();
    check("in_ready during rst", 32'(bus.in_ready), 32'd0);
    check("mem_we during rst", 32'(bus.mem_we), 32'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    exp_count = 0;
    exp_addr  = 0;
    exp_full  = 1'b0;
    exp_err   = 1'b0;
    check("reset mem_we", 32'(bus.mem_we), 32'd0);
    check("reset mem_wdata", bus.mem_wdata, 32'd0);
    check_status("reset");
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);

    // Table of encodings, legal and illegal.
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i]);
    end

    // Fill memory, then hold a fifth request: nothing may be written.
    do_clear();
    for (int i = 0; i < 4; i++) apply(vecs[0]);
    check("full flag", 32'(bus.full), 32'd1);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("held in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      check("held mem_we", 32'(bus.mem_we), 32'd0);
    end
    bus.in_valid = 1'b0;
    check_status("held");

    // Clear arriving during WRITE: word still written, pointer then reset.
    do_clear();
    apply(vecs[1]);
    bus.in_valid = 1'b1;
    #1;
    tick();
    bus.in_valid = 1'b0;
    bus.clear    = 1'b1;
    #1;
    check("clear-write mem_we", 32'(bus.mem_we), 32'd1);
    check("clear-write addr", 32'(bus.mem_addr), 32'd4);
    tick();
    bus.clear = 1'b0;
    exp_count = 0;
    exp_addr  = 0;
    exp_full  = 1'b0;
    exp_err   = 1'b0;
    check("after clear-write mem_we", 32'(bus.mem_we), 32'd0);
    check_status("after clear-write");

    // Reset arriving during WRITE.
    apply(vecs[2]);
    bus.op  = 2'd0;
    bus.imm = 13'd5;
    bus.in_valid = 1'b1;
    #1;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst-write mem_we", 32'(bus.mem_we), 32'd1);
    check("rst-write in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    rst = 1'b0;
    exp_count = 0;
    exp_addr  = 0;
    exp_full  = 1'b0;
    exp_err   = 1'b0;
    check("after rst mem_wdata", bus.mem_wdata, 32'd0);
    check("after rst mem_we", 32'(bus.mem_we), 32'd0);
    check_status("after rst");

`ifdef ENCODER_NOP_PAD_EN
    // One ADDI, then pad (with a competing in_valid that must lose).
    apply(vecs[0]);
    bus.pad_req  = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    check("pad in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    bus.pad_req  = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("pad mem_we", 32'(bus.mem_we), 32'd1);
      check("pad wdata", bus.mem_wdata, 32'h0000_0013);
      check("pad addr", 32'(bus.mem_addr), 32'(4 + 4 * k));
      #1;
      check("pad busy in_ready", 32'(bus.in_ready), 32'd0);
      tick();
    end
    exp_count = 4;
    exp_addr  = 12;
    exp_full  = 1'b1;
    check("post-pad mem_we", 32'(bus.mem_we), 32'd0);
    check_status("post-pad");
`else
    // pad_req has no effect: the instruction is accepted normally.
    bus.op       = vecs[1].op;
    bus.rd       = vecs[1].rd;
    bus.rs1      = vecs[1].rs1;
    bus.rs2      = vecs[1].rs2;
    bus.imm      = vecs[1].imm;
    bus.pad_req  = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    check("nopad in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("nopad mem_we", 32'(bus.mem_we), 32'd1);
    check("nopad wdata", bus.mem_wdata, vecs[1].wdata);
    model_write();
    tick();
    check("nopad idle mem_we", 32'(bus.mem_we), 32'd0);
    tick();
    bus.pad_req = 1'b0;
    check("nopad no pad mem_we", 32'(bus.mem_we), 32'd0);
    check_status("nopad");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
